// File: rtl/heartbeat_seg_driver.sv
// ---------------------------------------------------------------------------
// heartbeat_seg_driver
//
// Purpose:
//   Display-side consumer of the heartbeat animation pattern. It scans the
//   pattern onto a 4-digit common-anode 7-segment display, one digit per scan
//   slot. The pattern is copied into shadow registers once per frame, so a
//   displayed frame never mixes two animation states.
//
// Optional feature (compile-time macro BLANK_GUARD_EN):
//   When defined, the anodes are held off for the first GUARD_CYCLES cycles
//   of every slot. This dead time stops the previous digit ghosting onto the
//   next one. The cathodes still change at slot start, and frame/snapshot
//   timing is unchanged. When undefined, there is no dead time.
//
// Parameters:
//   REFRESH_DVSR  clk cycles per digit slot (>= 2)
//   GUARD_CYCLES  anode dead-time cycles at slot start (1..REFRESH_DVSR-1)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   en          in   scan enable; 0 freezes counters and blanks the display
//   an_en[3:0]  in   digit enable pattern, 1 = digit lit
//   line[3:0]   in   per-digit side: 1 = right line (b,c), 0 = left (e,f)
//   an[3:0]     out  anode drives, active-low, at most one low
//   seg[6:0]    out  cathodes {g,f,e,d,c,b,a}, active-low
//   dp          out  decimal point, active-low, always inactive
//   frame_tick  out  one-cycle pulse when the pattern snapshot is taken
// ---------------------------------------------------------------------------
module heartbeat_seg_driver #(
    parameter int REFRESH_DVSR = 50000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] an_en,
    input  logic [3:0] line,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int              CNT_W    = (REFRESH_DVSR > 2) ? $clog2(REFRESH_DVSR) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DVSR - 1);

    localparam logic [6:0] SEG_RIGHT = 7'b1111001;  // b,c lit
    localparam logic [6:0] SEG_LEFT  = 7'b1001111;  // e,f lit
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    // Reject illegal parameter combinations at elaboration time.
    if (REFRESH_DVSR < 2) begin : g_dvsr_illegal
        $error("heartbeat_seg_driver: REFRESH_DVSR must be >= 2");
    end
    if (GUARD_CYCLES < 1 || GUARD_CYCLES >= REFRESH_DVSR) begin : g_guard_illegal
        $error("heartbeat_seg_driver: GUARD_CYCLES must be in 1..REFRESH_DVSR-1");
    end

    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       sh_en;
    logic [3:0]       sh_line;
    logic             scan_tick;
    logic             snap;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;

    assign scan_tick = en && (slot_cnt == SLOT_LAST);
    assign snap      = scan_tick && (digit_idx == 2'd3);
    assign dp        = 1'b1;

    // Scan counters and the per-frame pattern snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt   <= '0;
            digit_idx  <= 2'd0;
            sh_en      <= 4'h0;
            sh_line    <= 4'h0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= snap;
            if (en) begin
                slot_cnt <= scan_tick ? '0 : slot_cnt + 1'b1;
            end
            if (scan_tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
            if (snap) begin
                sh_en   <= an_en;
                sh_line <= line;
            end
        end
    end

    // Next anode/cathode values are derived from the current slot state.
    // The anode and cathode registers load on the same edge, so an anode
    // is never low while its cathodes are still settling.
    always_comb begin
        an_nxt  = 4'hF;
        seg_nxt = SEG_OFF;
        if (en && sh_en[digit_idx]) begin
            an_nxt  = ~(4'b0001 << digit_idx);
            seg_nxt = sh_line[digit_idx] ? SEG_RIGHT : SEG_LEFT;
        end
`ifdef BLANK_GUARD_EN
        if (slot_cnt < CNT_W'(GUARD_CYCLES)) begin
            an_nxt = 4'hF;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an  <= 4'hF;
            seg <= SEG_OFF;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_heartbeat_seg_driver.sv
// ---------------------------------------------------------------------------
// tb_heartbeat_seg_driver
//
// Directed bench for heartbeat_seg_driver with REFRESH_DVSR=4 and
// GUARD_CYCLES=1. Each frame is 16 cycles. The expected anode and cathode
// values for each pattern are hand-computed constants. They are packed one
// nibble or one 7-bit field per digit, with digit 0 in the low bits.
//
// Outputs lag the scan state by one cycle. The value seen after edge t of a
// frame therefore belongs to digit (t-1)/4. Edge 1 of a frame is the first
// edge after that frame's frame_tick.
// ---------------------------------------------------------------------------
module tb_heartbeat_seg_driver;

    localparam int N_DVSR = 4;
    localparam int N_GUARD = 1;

    localparam logic [15:0] P1_AN = 16'hFBDF;
    localparam logic [27:0] P1_SEG = {7'h7F, 7'h79, 7'h4F, 7'h7F};
    localparam logic [15:0] P2_AN = 16'h7FFE;
    localparam logic [27:0] P2_SEG = {7'h4F, 7'h7F, 7'h7F, 7'h79};
    localparam logic [15:0] P3_AN = 16'h7BDE;
    localparam logic [27:0] P3_SEG = {7'h4F, 7'h4F, 7'h4F, 7'h4F};

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en = 1'b1;
    logic [3:0] an_en = 4'h0;
    logic [3:0] line = 4'h0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    heartbeat_seg_driver #(
        .REFRESH_DVSR(N_DVSR),
        .GUARD_CYCLES(N_GUARD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .en(en),
        .an_en(an_en),
        .line(line),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Anode value after the dead-time mask. prev_slot is the slot count the
    // output was computed from.
    function automatic logic [3:0] guard_an(input logic [3:0] a, input int prev_slot);
`ifdef BLANK_GUARD_EN
        if (prev_slot < N_GUARD) return 4'hF;
`endif
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sixteen blank cycles with frame_tick only on the last one.
    task automatic check_blank_frame();
        for (int t = 1; t <= 16; t++) begin
            step();
            check_val("blank_an", 32'(an), 32'hF);
            check_val("blank_seg", 32'(seg), 32'h7F);
            check_val("blank_dp", 32'(dp), 32'h1);
            check_val("blank_tick", 32'(frame_tick), (t == 16) ? 32'h1 : 32'h0);
        end
    endtask

    // One full frame against a packed expectation. When chg_t is nonzero,
    // the new inputs are applied after edge chg_t.
    task automatic run_frame(input string tag, input logic [15:0] an_exp, input logic [27:0] seg_exp,
                             input int chg_t, input logic [3:0] n_en, input logic [3:0] n_line);
        int d;
        for (int t = 1; t <= 16; t++) begin
            step();
            d = (t - 1) / 4;
            check_val({tag, "_an"}, 32'(an), 32'(guard_an(an_exp[4*d +: 4], (t - 1) % 4)));
            check_val({tag, "_seg"}, 32'(seg), 32'(seg_exp[7*d +: 7]));
            check_val({tag, "_tick"}, 32'(frame_tick), (t == 16) ? 32'h1 : 32'h0);
            if (t == chg_t) begin
                an_en = n_en;
                line  = n_line;
            end
        end
    endtask

    initial begin
        // Asynchronous reset, with an enabled input pattern present.
        an_en = 4'hF;
        #3 reset_n = 1'b0;
        #1;
        check_val("rst_an", 32'(an), 32'hF);
        check_val("rst_seg", 32'(seg), 32'h7F);
        check_val("rst_dp", 32'(dp), 32'h1);
        check_val("rst_tick", 32'(frame_tick), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_hold_an", 32'(an), 32'hF);

        @(negedge clk);
        an_en   = 4'b0110;
        line    = 4'b0100;
        reset_n = 1'b1;
        check_blank_frame();

        // P1 is displayed. The change to P2 in slot 1 stays hidden until the next snapshot.
        run_frame("p1", P1_AN, P1_SEG, 6, 4'b1001, 4'b0001);
        // P2 is displayed. The change to P3 mid-frame stays hidden likewise.
        run_frame("p2", P2_AN, P2_SEG, 6, 4'hF, 4'h0);

        // P3 frame: digit 0, then digit 1 up to slot_cnt=2.
        for (int t = 1; t <= 6; t++) begin
            step();
            check_val("p3_pre_an", 32'(an),
                      32'(guard_an((t <= 4) ? 4'hE : 4'hD, (t - 1) % 4)));
            check_val("p3_pre_seg", 32'(seg), 32'h4F);
        end

        // Scan disabled for 10 cycles: the display blanks and nothing advances.
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("dis_an", 32'(an), 32'hF);
            check_val("dis_seg", 32'(seg), 32'h7F);
            check_val("dis_tick", 32'(frame_tick), 32'h0);
        end

        // Resume: digit 1 for two more cycles, then digit 2.
        en = 1'b1;
        step();
        check_val("res_an0", 32'(an), 32'(guard_an(4'hD, 2)));
        check_val("res_seg0", 32'(seg), 32'h4F);
        step();
        check_val("res_an1", 32'(an), 32'(guard_an(4'hD, 3)));
        step();
        check_val("res_an2", 32'(an), 32'(guard_an(4'hB, 0)));
        check_val("res_seg2", 32'(seg), 32'h4F);

        // Reset pulsed mid-slot on digit 2: outputs clear without waiting for a clock edge.
        #2 reset_n = 1'b0;
        #1;
        check_val("mid_rst_an", 32'(an), 32'hF);
        check_val("mid_rst_seg", 32'(seg), 32'h7F);
        check_val("mid_rst_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // The shadow was cleared, so the display stays blank for a whole frame.
        check_blank_frame();
        run_frame("p3", P3_AN, P3_SEG, 0, 4'hF, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
